pda_string_gen: RTL and testbench

Stimulus-side companion to the `pda` recognizer: it generates character strings of the form first_term^n1 second_term^n2 third_term^n3 followed by a NUL (8'h00) terminator. The strings are driven onto a byte stream that feeds `pda.in_char`. With equal counts it produces strings the recognizer must accept; unequal or zero counts give strings it must reject. It sits between the test/host controller and the recognizer, with a valid/ready output so it can also drive buffered consumers.

---
 rtl/pda_string_gen_if.sv | 30 +++
 rtl/pda_string_gen.sv | 131 +++++++++++++
 tb/tb_pda_string_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pda_string_gen_if.sv
// Handshake/bus bundle between a host (master) and the pda_string_gen (slave).
// Counts and terms are sampled by the generator only on an accepted start.
interface pda_string_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] cnt_first;
  logic [CNT_W-1:0] cnt_second;
  logic [CNT_W-1:0] cnt_third;
  logic [7:0]       first_term;
  logic [7:0]       second_term;
  logic [7:0]       third_term;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, cnt_first, cnt_second, cnt_third,
    output first_term, second_term, third_term, out_ready,
    input  out_char, out_valid, busy, done
  );

  modport slave (
    input  start, cnt_first, cnt_second, cnt_third,
    input  first_term, second_term, third_term, out_ready,
    output out_char, out_valid, busy, done
  );
endinterface

// File: rtl/pda_string_gen.sv
// Emits first^n1 second^n2 third^n3 followed by NUL on a valid/ready byte stream.
// First character one cycle after an accepted start; every output is a flop.
module pda_string_gen #(
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  pda_string_gen_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_SECOND = 3'd2;
  localparam logic [2:0] S_THIRD  = 3'd3;
  localparam logic [2:0] S_TERM   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic [CNT_W-1:0] cnt3_q, cnt3_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       term1_q, term1_d;
  logic [7:0]       term2_q, term2_d;
  logic [7:0]       term3_q, term3_d;
  logic [7:0]       out_char_q, out_char_d;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q, done_d;
  logic             accept;
  logic             hs;

  always_comb begin
    accept  = (state_q == S_IDLE) && bus.start;
    hs      = out_valid_q && bus.out_ready;
    state_d = state_q;
    cnt2_d  = cnt2_q;
    cnt3_d  = cnt3_q;
    rem_d   = rem_q;
    term1_d = term1_q;
    term2_d = term2_q;
    term3_d = term3_q;
    done_d  = 1'b0;

    if (accept) begin
      term1_d = bus.first_term;
      term2_d = bus.second_term;
      term3_d = bus.third_term;
      cnt2_d  = bus.cnt_second;
      cnt3_d  = bus.cnt_third;
      if (bus.cnt_first != CNT_ZERO) begin
        state_d = S_FIRST;
        rem_d   = bus.cnt_first;
      end else if (bus.cnt_second != CNT_ZERO) begin
        state_d = S_SECOND;
        rem_d   = bus.cnt_second;
      end else if (bus.cnt_third != CNT_ZERO) begin
        state_d = S_THIRD;
        rem_d   = bus.cnt_third;
      end else begin
        state_d = S_TERM;
      end
    end else if (hs) begin
      case (state_q)
        S_FIRST, S_SECOND, S_THIRD: begin
          // Leave the phase on its last character so rem never reaches zero.
          if (rem_q == CNT_ONE) begin
            if ((state_q == S_FIRST) && (cnt2_q != CNT_ZERO)) begin
              state_d = S_SECOND;
              rem_d   = cnt2_q;
            end else if ((state_q != S_THIRD) && (cnt3_q != CNT_ZERO)) begin
              state_d = S_THIRD;
              rem_d   = cnt3_q;
            end else begin
              state_d = S_TERM;
            end
          end else begin
            rem_d = rem_q - CNT_ONE;
          end
        end
        S_TERM: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_FIRST:  out_char_d = term1_d;
      S_SECOND: out_char_d = term2_d;
      S_THIRD:  out_char_d = term3_d;
      default:  out_char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt2_q      <= '0;
      cnt3_q      <= '0;
      rem_q       <= '0;
      term1_q     <= 8'h00;
      term2_q     <= 8'h00;
      term3_q     <= 8'h00;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt2_q      <= cnt2_d;
      cnt3_q      <= cnt3_d;
      rem_q       <= rem_d;
      term1_q     <= term1_d;
      term2_q     <= term2_d;
      term3_q     <= term3_d;
      out_char_q  <= out_char_d;
      out_valid_q <= (state_d != S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
    end
  end

  assign bus.out_char  = out_char_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pda_string_gen.sv
// Vector table plus hand sequences; accepted characters are scoreboarded against
// strings queued when each start is driven.
module tb_pda_string_gen;

  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  pda_string_gen_if #(.CNT_W(CNT_W)) bus ();
  pda_string_gen #(.CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] c1, c2, c3;
    logic [7:0] t1, t2, t3;
    int         stall_idx;
    int         stall_len;
    int         pulse_at;
    int         exp_done;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  vec_t       vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] c1, c2, c3, t1, t2, t3,
                              input int stall_idx, stall_len, pulse_at, exp_done);
    vec_t v;
    v.c1 = c1; v.c2 = c2; v.c3 = c3;
    v.t1 = t1; v.t2 = t2; v.t3 = t3;
    v.stall_idx = stall_idx; v.stall_len = stall_len;
    v.pulse_at = pulse_at;   v.exp_done = exp_done;
    return v;
  endfunction

  task automatic push_string(input logic [7:0] c1, c2, c3, t1, t2, t3);
    for (int i = 0; i < int'(c1); i++) exp_q.push_back(t1);
    for (int i = 0; i < int'(c2); i++) exp_q.push_back(t2);
    for (int i = 0; i < int'(c3); i++) exp_q.push_back(t3);
    exp_q.push_back(8'h00);
  endtask

  // Scoreboard: pop on every handshake, hold check after every stalled valid cycle.
  always @(negedge clock) begin : mon
    logic [7:0] e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {23'd0, bus.out_valid, bus.out_char}, {23'd0, 1'b1, prev_char});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_char", 32'(bus.out_char), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("char", 32'(bus.out_char), 32'(e));
        end
      end else if (!bus.out_valid) begin
        check("idle_char", 32'(bus.out_char), 32'h0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_char  = bus.out_char;
    end
  end

  task automatic run_string(input vec_t v, input int id);
    int idx;
    int stalled;
    int done_cyc;
    @(posedge clock); #1;
    bus.start       = 1'b1;
    bus.cnt_first   = v.c1;
    bus.cnt_second  = v.c2;
    bus.cnt_third   = v.c3;
    bus.first_term  = v.t1;
    bus.second_term = v.t2;
    bus.third_term  = v.t3;
    bus.out_ready   = 1'b1;
    push_string(v.c1, v.c2, v.c3, v.t1, v.t2, v.t3);
    @(posedge clock); #1;
    bus.start       = 1'b0;
    bus.cnt_first   = 8'($urandom_range(255, 1));
    bus.cnt_second  = 8'($urandom_range(255, 1));
    bus.cnt_third   = 8'($urandom_range(255, 1));
    bus.first_term  = 8'($urandom_range(255, 1));
    bus.second_term = 8'($urandom_range(255, 1));
    bus.third_term  = 8'($urandom_range(255, 1));
    idx = 0; stalled = 0; done_cyc = -1;
    for (int cyc = 1; cyc < 600; cyc++) begin
      bus.start = (cyc == v.pulse_at);
      if (idx == v.stall_idx && stalled < v.stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
      end
      @(negedge clock);
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      check($sformatf("busy_v%0d_c%0d", id, cyc), 32'(bus.busy), 32'h1);
      if (bus.out_valid && bus.out_ready) idx++;
      @(posedge clock); #1;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    check($sformatf("done_cycle_v%0d", id), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("done_cycle_outs_v%0d", id), {30'd0, bus.out_valid, bus.busy}, 32'h0);
    check($sformatf("queue_empty_v%0d", id), 32'(exp_q.size()), 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    check($sformatf("after_done_v%0d", id), {30'd0, bus.done, bus.out_valid}, 32'h0);
  endtask

  initial begin
    vecs[0] = mk(8'd1,   8'd1, 8'd1, 8'h61, 8'h62, 8'h63, -1, 0, -1, 5);
    vecs[1] = mk(8'd3,   8'd3, 8'd3, 8'h61, 8'h62, 8'h63, -1, 0, -1, 11);
    vecs[2] = mk(8'd0,   8'd0, 8'd0, 8'h61, 8'h62, 8'h63, -1, 0, -1, 2);
    vecs[3] = mk(8'd2,   8'd0, 8'd1, 8'h61, 8'h62, 8'h63, -1, 0, -1, 5);
    vecs[4] = mk(8'd2,   8'd2, 8'd2, 8'h61, 8'h62, 8'h63,  2, 3, -1, 11);
    vecs[5] = mk(8'd3,   8'd2, 8'd3, 8'h61, 8'h62, 8'h63, -1, 0, -1, 10);
    vecs[6] = mk(8'd0,   8'd5, 8'd0, 8'h78, 8'h79, 8'h7a, -1, 0, -1, 7);
    vecs[7] = mk(8'd1,   8'd3, 8'd1, 8'h70, 8'h71, 8'h72, -1, 0,  3, 7);
    vecs[8] = mk(8'd255, 8'd0, 8'd1, 8'h6d, 8'h6e, 8'h6f, -1, 0, -1, 258);
    vecs[9] = mk(8'd0,   8'd0, 8'd1, 8'h41, 8'h42, 8'h43, -1, 0, -1, 3);

    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.cnt_first   = '0;
    bus.cnt_second  = '0;
    bus.cnt_third   = '0;
    bus.first_term  = 8'h00;
    bus.second_term = 8'h00;
    bus.third_term  = 8'h00;
    bus.out_ready   = 1'b1;
    #12;
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check("reset_out_char",  32'(bus.out_char),  32'h0);
    check("reset_busy",      32'(bus.busy),      32'h0);
    check("reset_done",      32'(bus.done),      32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_string(vecs[i], i);

    // Reset in the middle of the THIRD phase abandons the string.
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.cnt_first = 8'd1; bus.cnt_second = 8'd1; bus.cnt_third = 8'd4;
    bus.first_term = 8'h61; bus.second_term = 8'h62; bus.third_term = 8'h63;
    push_string(8'd1, 8'd1, 8'd4, 8'h61, 8'h62, 8'h63);
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    check("mid_third_char", {23'd0, bus.out_valid, bus.out_char}, {23'd0, 1'b1, 8'h63});
    reset_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'h0);
    check("async_busy",      32'(bus.busy),      32'h0);
    check("async_done",      32'(bus.done),      32'h0);
    check("async_out_char",  32'(bus.out_char),  32'h0);
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_string(mk(8'd1, 8'd2, 8'd1, 8'h64, 8'h65, 8'h66, -1, 0, -1, 6), 10);

    // start held high across done: second string begins the cycle after done.
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.cnt_first = 8'd1; bus.cnt_second = 8'd0; bus.cnt_third = 8'd1;
    bus.first_term = 8'h64; bus.second_term = 8'h65; bus.third_term = 8'h66;
    push_string(8'd1, 8'd0, 8'd1, 8'h64, 8'h65, 8'h66);
    push_string(8'd1, 8'd0, 8'd1, 8'h64, 8'h65, 8'h66);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 5) bus.start = 1'b0;
      @(negedge clock);
      check($sformatf("held_done_c%0d", cyc), 32'(bus.done), 32'((cyc == 4) || (cyc == 8)));
      check($sformatf("held_valid_c%0d", cyc), 32'(bus.out_valid), 32'(!((cyc == 4) || (cyc == 8))));
    end
    check("held_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
